// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard/stall controller for a 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
// It generates per-stage hold, flush and bubble controls for three cases:
//   - load-use hazards,
//   - taken-branch squash,
//   - multi-cycle data-memory waits, with a fatal timeout.
// Registers are one-hot 32-bit select vectors. Bit 31 (XZR) never creates a hazard.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall
// counter. Without it, stall_count is tied to zero.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,   // 1..7
  parameter int MEM_TIMEOUT       = 15,  // 1..255
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      ifid_rsa_sel,
  input  logic [31:0]      ifid_rsb_sel,
  input  logic             ifid_uses_b,
  input  logic [31:0]      idex_dsel,
  input  logic             idex_load,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FAULT      = 2'd3
  } state_e;

  localparam logic [2:0]  REM_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0]  TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [31:0] REG_MASK = 32'h7FFF_FFFF;  // drop XZR

  state_e     state_q, state_d;
  logic [2:0] rem_q, rem_d;            // load-stall bubbles still owed
  logic [7:0] wait_cnt_q, wait_cnt_d;  // freeze cycles in the current memory wait

  logic [31:0] src_sel;
  logic        hazard;
  logic        mem_stall;
  logic        freeze;   // whole pipeline held, MEM/WB gets a bubble
  logic        squash;   // taken branch: flush younger stages
  logic        stall;    // load-use: hold front end, bubble into ID/EX
  logic        fault;

  assign src_sel   = ifid_rsa_sel | (ifid_uses_b ? ifid_rsb_sel : 32'd0);
  assign hazard    = idex_load & |(idex_dsel & src_sel & REG_MASK);
  assign mem_stall = mem_req & ~mem_ready;

  // State register plus the stall and wait bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      rem_q      <= 3'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and control decode. Priority: memory wait > branch > load-use.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    squash     = 1'b0;
    stall      = 1'b0;
    fault      = 1'b0;
    if (state_q == FAULT) begin
      freeze = 1'b1;
      fault  = 1'b1;
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      // EX/MEM is frozen, so a branch resolved there waits for release
      freeze     = 1'b1;
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_d == TIMEOUT) state_d = FAULT;
    end else if (mem_stall) begin
      // A wait that starts during LOAD_STALL leaves rem untouched so the
      // stall resumes once memory releases
      freeze     = 1'b1;
      wait_cnt_d = 8'd1;
      state_d    = (TIMEOUT == 8'd1) ? FAULT : MEM_WAIT;
    end else begin
      wait_cnt_d = 8'd0;
      if (branch_taken) begin
        // Squashing the consumer also cancels any pending load-use bubbles
        squash  = 1'b1;
        rem_d   = 3'd0;
        state_d = RUN;
      end else if (state_q == LOAD_STALL) begin
        stall   = 1'b1;
        rem_d   = rem_q - 3'd1;
        state_d = (rem_q <= 3'd1) ? RUN : LOAD_STALL;
      end else if (hazard) begin
        stall = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          rem_d   = REM_INIT;
          state_d = LOAD_STALL;
        end else begin
          rem_d   = 3'd0;
          state_d = RUN;
        end
      end else if (rem_q != 3'd0) begin
        // Releasing a memory wait that interrupted a load stall
        state_d = LOAD_STALL;
      end else begin
        state_d = RUN;
      end
    end
  end

  // While rstn is low the outputs are forced to their reset values,
  // with no clock edge needed
  assign pc_en        = rstn & ~freeze & ~stall;
  assign ifid_en      = rstn & ~freeze & ~stall;
  assign ifid_flush   = ~rstn | squash;
  assign idex_en      = rstn & ~freeze;
  assign idex_bubble  = ~rstn | squash | stall;
  assign exmem_en     = rstn & ~freeze;
  assign exmem_bubble = ~rstn | squash;
  assign memwb_bubble = ~rstn | freeze;
  assign mem_timeout  = rstn & fault;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = (!pc_en && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl.
// The driver issues directed vectors and pushes the hand-computed control
// word for each one into a scoreboard queue. The monitor pops one entry per
// cycle on the falling edge and compares it with the DUT outputs.
module tb_pipeline_hazard_ctrl;

  // Control word: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
  //                exmem_en, exmem_bubble, memwb_bubble, mem_timeout}
  localparam logic [8:0] RUNV = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] HAZ  = 9'b0_0_0_1_1_1_0_0_0;
  localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] FRZ  = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] FLT  = 9'b0_0_0_0_0_0_0_1_1;
  localparam logic [8:0] RST  = 9'b0_0_1_0_1_0_1_1_0;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] rsa, rsb, dsel;
  logic        uses_b, ld, br, mreq, mrdy;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic        exmem_en, exmem_bubble, memwb_bubble, mem_timeout;
  logic [15:0] stall_count;

  typedef struct {
    logic [8:0]  ctl;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(2),
    .MEM_TIMEOUT(15),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ifid_rsa_sel(rsa),
    .ifid_rsb_sel(rsb),
    .ifid_uses_b(uses_b),
    .idex_dsel(dsel),
    .idex_load(ld),
    .branch_taken(br),
    .mem_req(mreq),
    .mem_ready(mrdy),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .idex_en(idex_en),
    .idex_bubble(idex_bubble),
    .exmem_en(exmem_en),
    .exmem_bubble(exmem_bubble),
    .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  // Drive one cycle's inputs and queue the expected outputs for that cycle
  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic ub, input logic l,
                       input logic bt, input logic mq, input logic my,
                       input logic [8:0] ctl, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = r; rsa = a; rsb = b; dsel = d; uses_b = ub;
    ld = l; br = bt; mreq = mq; mrdy = my;
    if (!r) stalls = 0;
    e.ctl  = ctl;
`ifdef HAZARD_PERF_CNT_EN
    e.cnt  = 16'(stalls);
`else
    e.cnt  = 16'd0;
`endif
    if (r && !ctl[8]) stalls++;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // A quiet cycle with the expected controls given
  task automatic cyc(input logic [8:0] ctl, input string name);
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ctl, name);
  endtask

  // Monitor: one comparison pair per presented cycle
  initial begin : monitor
    exp_t       e;
    logic [8:0] act;
    logic       ok_ctl, ok_cnt;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, exmem_bubble, memwb_bubble, mem_timeout};
        ok_ctl = (act === e.ctl);
        ok_cnt = (stall_count === e.cnt);
        checks += 2;
        if (!ok_ctl) errors++;
        if (!ok_cnt) errors++;
        if (ok_ctl && ok_cnt)
          $display("ok   %-20s ctl=%b stall_count=%0d", e.name, act, stall_count);
        else
          $display("FAIL %-20s ctl got %b want %b, stall_count got %0d want %0d",
                   e.name, act, e.ctl, stall_count, e.cnt);
      end
    end
  end

  initial begin : driver
    rstn = 1'b0; rsa = '0; rsb = '0; dsel = '0;
    uses_b = 1'b0; ld = 1'b0; br = 1'b0; mreq = 1'b0; mrdy = 1'b1;

    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RST, "reset0");
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RST, "reset1");
    cyc(RUNV, "post_reset");

    // Load-use on source A with 2 stall cycles
    drive(1'b1, 32'd1 << 3, 32'd0, 32'd1 << 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, HAZ, "t1_rsa_hazard");
    cyc(HAZ,  "t1_stall2");
    cyc(RUNV, "t1_resume");
    // Load-use on source B, and source B ignored for immediate forms
    drive(1'b1, 32'd0, 32'd1 << 5, 32'd1 << 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, HAZ, "t1b_rsb_hazard");
    cyc(HAZ,  "t1b_stall2");
    cyc(RUNV, "t1b_resume");
    drive(1'b1, 32'd0, 32'd1 << 5, 32'd1 << 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RUNV, "t1c_imm_no_haz");
    drive(1'b1, 32'd1 << 3, 32'd0, 32'd1 << 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUNV, "t1d_nonload");

    // XZR never creates a hazard
    drive(1'b1, 32'd1 << 31, 32'd1 << 31, 32'd1 << 31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RUNV, "t2_xzr");
    cyc(RUNV, "t2_after");

    // Branch beats load-use in the same cycle
    drive(1'b1, 32'd1 << 3, 32'd0, 32'd1 << 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, BR, "t3_branch_haz");
    cyc(RUNV, "t3_no_stall");

    // Four-cycle memory wait: a branch during the wait is ignored,
    // a branch on the release cycle is honoured
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RST, "t4_pre_reset");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, "t4_wait1");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, "t4_wait2");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, "t4_wait3_branch");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, "t4_wait4");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, BR,  "t4_release_br");
    cyc(RUNV, "t4_after");

    // A memory wait preempts a load stall, and the owed bubble follows release
    drive(1'b1, 32'd1 << 7, 32'd0, 32'd1 << 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, HAZ, "pre_hazard");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, "pre_wait1");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, "pre_wait2");
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RUNV, "pre_release");
    cyc(HAZ,  "pre_resume_stall");
    cyc(RUNV, "pre_done");

    // Timeout: 15 freeze cycles, then a sticky FAULT cleared only by reset
    for (int i = 1; i <= 15; i++)
      drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, $sformatf("t5_wait%0d", i));
    drive(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FLT, "t5_fault");
    cyc(FLT, "t5_sticky1");
    drive(1'b1, 32'd1 << 3, 32'd0, 32'd1 << 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, FLT, "t5_sticky2");
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RST, "t5_reset");
    cyc(RUNV, "t5_run");

    // Reset in the middle of a load stall leaves nothing behind
    drive(1'b1, 32'd1 << 3, 32'd0, 32'd1 << 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, HAZ, "t6_hazard");
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RST, "t6_reset_mid");
    cyc(RUNV, "t6_no_bubble");
    cyc(RUNV, "t6_run");

    // Let the monitor drain the queue, with a bound
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain scoreboard entries left %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
